// File: rtl/alu_mdu_seq.sv
// alu_mdu_seq: EX-stage ALU with registered single-cycle ops and an iterative
// multiply/divide unit (radix-2 shift-add multiply, restoring divide).
// Single-cycle results land one edge after start; mult/div take WIDTH edges.
// Optional feature: define ALU_OVF_EN to add the registered Overflow output.
module alu_mdu_seq #(
    parameter int WIDTH = 32,
    parameter int OPW   = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [OPW-1:0]   ALUOp,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic [WIDTH-1:0] C,
    output logic [WIDTH-1:0] HI,
    output logic [WIDTH-1:0] LO,
    output logic             busy,
    output logic             done
`ifdef ALU_OVF_EN
    ,
    output logic             Overflow
`endif
);

    localparam int CW = $clog2(WIDTH);

    localparam logic [OPW-1:0] OP_ADDU  = OPW'(0);
    localparam logic [OPW-1:0] OP_SUBU  = OPW'(1);
    localparam logic [OPW-1:0] OP_OR    = OPW'(2);
    localparam logic [OPW-1:0] OP_ADD   = OPW'(3);
    localparam logic [OPW-1:0] OP_AND   = OPW'(4);
    localparam logic [OPW-1:0] OP_SLT   = OPW'(5);
    localparam logic [OPW-1:0] OP_SLTU  = OPW'(6);
    localparam logic [OPW-1:0] OP_MULT  = OPW'(16);
    localparam logic [OPW-1:0] OP_MULTU = OPW'(17);
    localparam logic [OPW-1:0] OP_DIV   = OPW'(18);
    localparam logic [OPW-1:0] OP_DIVU  = OPW'(19);

    typedef enum logic [0:0] {S_IDLE, S_RUN} state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   c_q, c_d, hi_q, hi_d, lo_q, lo_d;
    logic               done_q, done_d;
    // Latched operands for the one-edge-later single-cycle completion
    logic [OPW-1:0]     op_q, op_d;
    logic [WIDTH-1:0]   a_q, a_d, b_q, b_d;
    logic               one_q, one_d;
    // Iterative datapath: acc = {upper, lower} shared by mult and div
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0]   opd_q, opd_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic               div_q, div_d;
    logic               neg_q, neg_d;      // product / quotient negate
    logic               neg_r_q, neg_r_d;  // remainder negate (dividend sign)
`ifdef ALU_OVF_EN
    logic               ovf_q, ovf_d;
    logic [WIDTH-1:0]   sum_r, dif_r;
`endif

    logic               accept, is_mul, is_div, sgn;
    logic [WIDTH-1:0]   abs_a, abs_b;
    logic [WIDTH:0]     mul_sum, div_sh;
    logic               div_ge;
    logic [WIDTH-1:0]   div_rem;
    logic [2*WIDTH-1:0] mul_nxt, div_nxt, prod_fin;

    // One step of the shift-add multiplier and of the restoring divider
    always_comb begin
        mul_sum = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opd_q} : '0);
        mul_nxt = {mul_sum, acc_q[WIDTH-1:1]};
        div_sh  = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
        div_ge  = div_sh >= {1'b0, opd_q};
        // Remainder is always below the divisor, so WIDTH bits suffice
        div_rem = div_ge ? (div_sh[WIDTH-1:0] - opd_q) : div_sh[WIDTH-1:0];
        div_nxt = {div_rem, acc_q[WIDTH-2:0], div_ge};
        prod_fin = neg_q ? -mul_nxt : mul_nxt;
    end

    // Next-state, operand capture, result writeback
    always_comb begin
        state_d = state_q;
        c_d     = c_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        done_d  = 1'b0;
        op_d    = op_q;
        a_d     = a_q;
        b_d     = b_q;
        one_d   = 1'b0;
        acc_d   = acc_q;
        opd_d   = opd_q;
        cnt_d   = cnt_q;
        div_d   = div_q;
        neg_d   = neg_q;
        neg_r_d = neg_r_q;

        accept = start && (state_q == S_IDLE);
        is_mul = (ALUOp == OP_MULT) || (ALUOp == OP_MULTU);
        is_div = (ALUOp == OP_DIV)  || (ALUOp == OP_DIVU);
        sgn    = (ALUOp == OP_MULT) || (ALUOp == OP_DIV);
        abs_a  = (sgn && A[WIDTH-1]) ? -A : A;
        abs_b  = (sgn && B[WIDTH-1]) ? -B : B;

        // Finish a single-cycle op (also divide-by-zero and undefined opcodes)
        if (one_q) begin
            done_d = 1'b1;
            case (op_q)
                OP_ADDU, OP_ADD: c_d = a_q + b_q;
                OP_SUBU:         c_d = a_q - b_q;
                OP_OR:           c_d = a_q | b_q;
                OP_AND:          c_d = a_q & b_q;
                OP_SLT:          c_d = {{(WIDTH-1){1'b0}}, $signed(a_q) < $signed(b_q)};
                OP_SLTU:         c_d = {{(WIDTH-1){1'b0}}, a_q < b_q};
                OP_DIV, OP_DIVU: begin
                    hi_d = a_q;
                    lo_d = '1;
                end
                default:         c_d = '0;
            endcase
        end

        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    op_d = ALUOp;
                    a_d  = A;
                    b_d  = B;
                    if (is_mul) begin
                        acc_d   = {{WIDTH{1'b0}}, abs_b};
                        opd_d   = abs_a;
                        div_d   = 1'b0;
                        neg_d   = sgn && (A[WIDTH-1] ^ B[WIDTH-1]);
                        neg_r_d = 1'b0;
                        cnt_d   = '0;
                        state_d = S_RUN;
                    end else if (is_div && (B != '0)) begin
                        acc_d   = {{WIDTH{1'b0}}, abs_a};
                        opd_d   = abs_b;
                        div_d   = 1'b1;
                        neg_d   = sgn && (A[WIDTH-1] ^ B[WIDTH-1]);
                        neg_r_d = sgn && A[WIDTH-1];
                        cnt_d   = '0;
                        state_d = S_RUN;
                    end else begin
                        one_d = 1'b1;
                    end
                end
            end
            S_RUN: begin
                acc_d = div_q ? div_nxt : mul_nxt;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CW'(WIDTH-1)) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                    if (div_q) begin
                        hi_d = neg_r_q ? -div_nxt[2*WIDTH-1:WIDTH] : div_nxt[2*WIDTH-1:WIDTH];
                        lo_d = neg_q   ? -div_nxt[WIDTH-1:0]       : div_nxt[WIDTH-1:0];
                    end else begin
                        hi_d = prod_fin[2*WIDTH-1:WIDTH];
                        lo_d = prod_fin[WIDTH-1:0];
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

`ifdef ALU_OVF_EN
    // Signed overflow for ADD and for SUBU viewed as signed; cleared by other single-cycle ops
    always_comb begin
        ovf_d = ovf_q;
        sum_r = a_q + b_q;
        dif_r = a_q - b_q;
        if (one_q) begin
            if (op_q == OP_ADD)
                ovf_d = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (sum_r[WIDTH-1] != a_q[WIDTH-1]);
            else if (op_q == OP_SUBU)
                ovf_d = (a_q[WIDTH-1] != b_q[WIDTH-1]) && (dif_r[WIDTH-1] != a_q[WIDTH-1]);
            else if (!((op_q == OP_DIV) || (op_q == OP_DIVU)))
                ovf_d = 1'b0;
        end
    end

    // Overflow register
    always_ff @(posedge clk) begin
        if (rst) ovf_q <= 1'b0;
        else     ovf_q <= ovf_d;
    end

    assign Overflow = ovf_q;
`endif

    // State and datapath registers; reset aborts any running op
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            c_q     <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            done_q  <= 1'b0;
            op_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            one_q   <= 1'b0;
            acc_q   <= '0;
            opd_q   <= '0;
            cnt_q   <= '0;
            div_q   <= 1'b0;
            neg_q   <= 1'b0;
            neg_r_q <= 1'b0;
        end else begin
            state_q <= state_d;
            c_q     <= c_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            done_q  <= done_d;
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
            one_q   <= one_d;
            acc_q   <= acc_d;
            opd_q   <= opd_d;
            cnt_q   <= cnt_d;
            div_q   <= div_d;
            neg_q   <= neg_d;
            neg_r_q <= neg_r_d;
        end
    end

    assign C    = c_q;
    assign HI   = hi_q;
    assign LO   = lo_q;
    assign busy = (state_q == S_RUN);
    assign done = done_q;

endmodule
